// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: ID/EX hazard inputs and pipeline-control outputs.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; the controller's enables are the pipeline's backpressure.
//
// master: the pipeline side (drives ID/EX state, consumes enables).
// slave : the hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int OPC_W  = 7,
    parameter int PERF_W = 32
);
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [REG_AW-1:0] ID_EX_rd;
    logic              ID_EX_MemRead;
    logic              EX_MulDiv;
    logic              EQ;
    logic              ControlReset;
    logic              PCWrite;
    logic              IF_IDWrite;
    logic              ID_EXWrite;
    logic              IF_Flush;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] flush_cnt;

    modport master (
        output opcode, rs1, rs2, rs1_used, rs2_used, ID_EX_rd, ID_EX_MemRead,
               EX_MulDiv, EQ,
        input  ControlReset, PCWrite, IF_IDWrite, ID_EXWrite, IF_Flush,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  opcode, rs1, rs2, rs1_used, rs2_used, ID_EX_rd, ID_EX_MemRead,
               EX_MulDiv, EQ,
        output ControlReset, PCWrite, IF_IDWrite, ID_EXWrite, IF_Flush,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, mul/div freeze, branch/jump flush.
// Latency: 0 cycles, enables respond combinationally in the cycle the hazard is seen.
// Backpressure: deasserts PCWrite/IF_IDWrite (and ID_EXWrite on freeze) for the stall window.
//
// Ports: clock, reset (synchronous, active-high); hz (hazard_ctrl_unit_if.slave)
//   carrying ID/EX hazard inputs and the PC / IF-ID / ID-EX enables,
//   ControlReset, IF_Flush and the stall/flush performance counters.
// Optional macro HAZARD_PERF_EN: enables saturating stall_cnt / flush_cnt;
//   without it both counters are tied to zero and no counter flops exist.
module hazard_ctrl_unit #(
    parameter int                REG_AW      = 5,
    parameter int                OPC_W       = 7,
    parameter logic [OPC_W-1:0]  OPC_BRANCH  = 7'b1100011,
    parameter logic [OPC_W-1:0]  OPC_JAL     = 7'b1101111,
    parameter logic [OPC_W-1:0]  OPC_JALR    = 7'b1100111,
    parameter int                LOAD_STALLS = 1,
    parameter int                MULDIV_LAT  = 4,
    parameter int                PERF_W      = 32
) (
    input  logic               clock,
    input  logic               reset,
    hazard_ctrl_unit_if.slave  hz
);
    localparam int CNT_MAX = (LOAD_STALLS > MULDIV_LAT) ? LOAD_STALLS : MULDIV_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_STALL = 2'd1,
        MD_BUSY  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic ld_hit;
    logic freeze;
    logic stall;
    logic flush_req;

    assign ld_hit = hz.ID_EX_MemRead && (hz.ID_EX_rd != '0) &&
                    ((hz.rs1_used && (hz.rs1 == hz.ID_EX_rd)) ||
                     (hz.rs2_used && (hz.rs2 == hz.ID_EX_rd)));

    assign flush_req = ((hz.opcode == OPC_BRANCH) && hz.EQ) ||
                       (hz.opcode == OPC_JAL) || (hz.opcode == OPC_JALR);

    // The first stall/freeze cycle is raised straight from IDLE so the hazard
    // is covered in the cycle it appears; the FSM only holds the remaining
    // cycles. Reset forces the free-flowing outputs regardless of state.
    assign freeze = !reset &&
                    ((state_q == MD_BUSY) || ((state_q == IDLE) && hz.EX_MulDiv));
    assign stall  = !reset && !freeze &&
                    ((state_q == LD_STALL) || ((state_q == IDLE) && ld_hit));

    assign hz.PCWrite      = !(freeze || stall);
    assign hz.IF_IDWrite   = !(freeze || stall);
    assign hz.ID_EXWrite   = !freeze;
    assign hz.ControlReset = stall;
    assign hz.IF_Flush     = !reset && flush_req && !freeze && !stall;

    // cnt holds the stall cycles still owed after the current one; leaving at
    // cnt==1 makes the total window exactly LOAD_STALLS / MULDIV_LAT cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz.EX_MulDiv) begin
                        if (MULDIV_LAT > 1) begin
                            state_q <= MD_BUSY;
                            cnt_q   <= CNT_W'(MULDIV_LAT - 1);
                        end
                    end else if (ld_hit) begin
                        if (LOAD_STALLS > 1) begin
                            state_q <= LD_STALL;
                            cnt_q   <= CNT_W'(LOAD_STALLS - 1);
                        end
                    end
                end
                LD_STALL, MD_BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!hz.PCWrite && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (hz.IF_Flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (A: LOAD_STALLS=1/MULDIV_LAT=4,
// B: LOAD_STALLS=3/MULDIV_LAT=2) share directed stimulus; a per-cycle model
// plus hand-computed literal checks compare their outputs.
// Output vector order: {PCWrite, IF_IDWrite, ID_EXWrite, ControlReset, IF_Flush}.
module tb_hazard_ctrl_unit;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    localparam logic [4:0] NRM = 5'b11100;
    localparam logic [4:0] STL = 5'b00110;
    localparam logic [4:0] FRZ = 5'b00000;
    localparam logic [4:0] FLS = 5'b11101;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [4:0] rs1 = '0, rs2 = '0, id_ex_rd = '0;
    logic       rs1_used = 1'b0, rs2_used = 1'b0, memread = 1'b0, muldiv = 1'b0, eq = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_AW(5), .OPC_W(7), .PERF_W(32)) ifa ();
    hazard_ctrl_unit_if #(.REG_AW(5), .OPC_W(7), .PERF_W(32)) ifb ();

    assign ifa.opcode = opcode;   assign ifb.opcode = opcode;
    assign ifa.rs1 = rs1;         assign ifb.rs1 = rs1;
    assign ifa.rs2 = rs2;         assign ifb.rs2 = rs2;
    assign ifa.rs1_used = rs1_used; assign ifb.rs1_used = rs1_used;
    assign ifa.rs2_used = rs2_used; assign ifb.rs2_used = rs2_used;
    assign ifa.ID_EX_rd = id_ex_rd; assign ifb.ID_EX_rd = id_ex_rd;
    assign ifa.ID_EX_MemRead = memread; assign ifb.ID_EX_MemRead = memread;
    assign ifa.EX_MulDiv = muldiv; assign ifb.EX_MulDiv = muldiv;
    assign ifa.EQ = eq;           assign ifb.EQ = eq;

    hazard_ctrl_unit #(.LOAD_STALLS(1), .MULDIV_LAT(4)) u_a (
        .clock(clk), .reset(reset), .hz(ifa.slave)
    );
    hazard_ctrl_unit #(.LOAD_STALLS(3), .MULDIV_LAT(2)) u_b (
        .clock(clk), .reset(reset), .hz(ifb.slave)
    );

    wire [4:0] oa = {ifa.PCWrite, ifa.IF_IDWrite, ifa.ID_EXWrite, ifa.ControlReset, ifa.IF_Flush};
    wire [4:0] ob = {ifb.PCWrite, ifb.IF_IDWrite, ifb.ID_EXWrite, ifb.ControlReset, ifb.IF_Flush};

    // ---------------- behavioural model ----------------
    // Each instance owes "rem" more stall cycles of a given kind; a new hazard
    // is only accepted when nothing is owed.
    int     ls_p[2]  = '{1, 3};
    int     lat_p[2] = '{4, 2};
    int     rem[2]   = '{0, 0};
    bit     is_md[2] = '{1'b0, 1'b0};
    longint m_stall[2] = '{0, 0};
    longint m_flush[2] = '{0, 0};

    function automatic bit hit_f();
        return memread && (id_ex_rd != 5'd0) &&
               ((rs1_used && rs1 == id_ex_rd) || (rs2_used && rs2 == id_ex_rd));
    endfunction

    function automatic bit flush_f();
        return (opcode == BR && eq) || opcode == JAL || opcode == JALR;
    endfunction

    always @(negedge clk) begin
        logic [4:0]  act [2];
        logic [31:0] sc  [2];
        logic [31:0] fc  [2];
        logic [4:0]  exp;
        act[0] = oa; act[1] = ob;
        sc[0] = ifa.stall_cnt; sc[1] = ifb.stall_cnt;
        fc[0] = ifa.flush_cnt; fc[1] = ifb.flush_cnt;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                exp = NRM;
                rem[i] = 0;
            end else if (rem[i] > 0) begin
                exp = is_md[i] ? FRZ : STL;
                rem[i] = rem[i] - 1;
            end else if (muldiv) begin
                exp = FRZ;
                rem[i] = lat_p[i] - 1;
                is_md[i] = 1'b1;
            end else if (hit_f()) begin
                exp = STL;
                rem[i] = ls_p[i] - 1;
                is_md[i] = 1'b0;
            end else begin
                exp = {4'b1110, flush_f()};
            end
            n_vec++;
            if (act[i] !== exp) begin
                n_bad++;
                $display("FAIL model_%0d t=%0t outputs got %b expected %b", i, $time, act[i], exp);
            end
            if (!reset) begin
`ifdef HAZARD_PERF_EN
                n_vec++;
                if (64'(sc[i]) != m_stall[i] || 64'(fc[i]) != m_flush[i]) begin
                    n_bad++;
                    $display("FAIL perf_%0d t=%0t got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             i, $time, sc[i], fc[i], m_stall[i], m_flush[i]);
                end
`else
                n_vec++;
                if (sc[i] !== 32'd0 || fc[i] !== 32'd0) begin
                    n_bad++;
                    $display("FAIL perf_off_%0d t=%0t got stall=%0d flush=%0d expected 0 0",
                             i, $time, sc[i], fc[i]);
                end
`endif
                m_stall[i] += (exp[4] == 1'b0) ? 1 : 0;
                m_flush[i] += exp[0] ? 1 : 0;
            end else begin
                m_stall[i] = 0;
                m_flush[i] = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [6:0] opc, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic md, input logic e, input logic rst);
        @(posedge clk);
        #1;
        opcode = opc; rs1 = r1; rs2 = r2; rs1_used = u1; rs2_used = u2;
        id_ex_rd = rd; memread = mr; muldiv = md; eq = e; reset = rst;
        @(negedge clk);
    endtask

    task automatic idle();
        step(7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial begin
        // reset gating: a mul/div pulse during reset must not freeze anything
        step(7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("rst_gate_a", oa, NRM); chk("rst_gate_b", ob, NRM);
        idle();
        chk("post_rst_a", oa, NRM); chk("post_rst_b", ob, NRM);

        // load-use on rs1: A stalls 1 cycle, B stalls 3
        step(7'd0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ld1_a_c1", oa, STL); chk("ld3_b_c1", ob, STL);
        idle();
        chk("ld1_a_c2", oa, NRM); chk("ld3_b_c2", ob, STL);
        idle();
        chk("ld3_b_c3", ob, STL);
        idle();
        chk("ld3_b_c4", ob, NRM);

        // no-hazard filters: load to x0, unused rs2
        step(7'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("x0_a", oa, NRM); chk("x0_b", ob, NRM);
        step(7'd0, 5'd0, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rs2_unused_a", oa, NRM);
        step(7'd0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rs2_used_a", oa, STL); chk("rs2_used_b", ob, STL);
        idle(); idle(); idle();

        // mul/div freeze: A 4 cycles, B 2; a load hazard in cycle 2 is ignored
        step(7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("md_a_c1", oa, FRZ); chk("md_b_c1", ob, FRZ);
        step(7'd0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("md_a_c2_ld_ign", oa, FRZ); chk("md_b_c2_ld_ign", ob, FRZ);
        idle();
        chk("md_a_c3", oa, FRZ); chk("md_b_c3", ob, NRM);
        idle();
        chk("md_a_c4", oa, FRZ);
        idle();
        chk("md_a_c5", oa, NRM);

        // branch taken behind a load: flush waits for the first free cycle
        step(BR, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("br_ld_a_c1", oa, STL); chk("br_ld_b_c1", ob, STL);
        step(BR, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("br_ld_a_c2", oa, FLS); chk("br_ld_b_c2", ob, STL);
        step(BR, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("br_ld_b_c3", ob, STL);
        step(BR, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("br_ld_b_c4", ob, FLS);
        idle();

        // jumps flush immediately, untaken branch does not
        step(JAL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jal_a", oa, FLS); chk("jal_b", ob, FLS);
        step(JALR, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jalr_a", oa, FLS);
        step(BR, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("br_nt_a", oa, NRM);

        // all three events at once: freeze wins, no bubble, no flush
        step(JAL, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("prio_a", oa, FRZ); chk("prio_b", ob, FRZ);
        idle(); idle();
        chk("prio_b_done", ob, NRM);
        idle();
        chk("prio_a_c4", oa, FRZ);
        idle();
        chk("prio_a_done", oa, NRM);

        // reset in cycle 2 of a mul/div freeze
        step(7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mdrst_a_c1", oa, FRZ);
        step(7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mdrst_a_rst", oa, NRM); chk("mdrst_b_rst", ob, NRM);
        idle();
        chk("mdrst_a_rel", oa, NRM); chk("mdrst_b_rel", ob, NRM);
        n_vec++;
        if (ifa.stall_cnt !== 32'd0 || ifa.flush_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL cnt_after_rst got stall=%0d flush=%0d expected 0 0",
                     ifa.stall_cnt, ifa.flush_cnt);
        end
        idle();
        chk("mdrst_a_c2", oa, NRM);
        idle(); idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
